// File: rtl/lc4_insn_cache_nway_pkg.sv
// Shared types and width helpers for the N-way LC4 instruction cache.
// Both the cache top and its LRU helper import this package.
package lc4_cache_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    // TAG_W = ADDR_W - SET_BITS
    function automatic int calc_tag_w(input int addr_w, input int set_bits);
        return addr_w - set_bits;
    endfunction

    // AGE_W = $clog2(WAYS); zero for a direct-mapped cache
    function automatic int calc_age_w(input int ways);
        return $clog2(ways);
    endfunction

    // Storage width for ages/way indices; never zero so vectors stay legal
    function automatic int calc_age_store_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/lc4_insn_cache_nway_if.sv
// Fill bus between the instruction cache (master) and instruction memory (slave).
interface lc4_insn_cache_nway_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_iaddr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_idata;

    modport master (output mem_req, output mem_iaddr, input mem_ack, input mem_idata);
    modport slave  (input mem_req, input mem_iaddr, output mem_ack, output mem_idata);
endinterface

// File: rtl/lc4_insn_cache_nway_lru.sv
// Victim selection and next-state ages for the one set being updated this cycle.
module lc4_cache_lru
    import lc4_cache_pkg::*;
#(
    parameter  int WAYS = 2,
    localparam int AW   = calc_age_store_w(WAYS)
) (
    input  logic [WAYS-1:0]         valid_bits,
    input  logic [WAYS-1:0][AW-1:0] ages,
    input  logic                    fill,
    input  logic [AW-1:0]           hit_way,
    output logic [AW-1:0]           victim,
    output logic [WAYS-1:0][AW-1:0] ages_next
);

    if (WAYS == 1) begin : g_dm
        assign victim    = '0;
        assign ages_next = ages;
    end else begin : g_lru
        logic          found;
        logic [AW-1:0] sel;

        always_comb begin
            victim = '0;
            found  = 1'b0;
            for (int w = 0; w < WAYS; w++) begin
                if (!found && !valid_bits[w]) begin
                    victim = AW'(w);
                    found  = 1'b1;
                end
            end
            // Ages form a permutation, so the oldest way holds WAYS-1
            if (!found) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (ages[w] == AW'(WAYS - 1)) victim = AW'(w);
                end
            end
            sel = fill ? victim : hit_way;
            for (int w = 0; w < WAYS; w++) begin
                ages_next[w] = ages[w];
                if (AW'(w) == sel)
                    ages_next[w] = '0;
                else if (ages[w] < ages[sel])
                    ages_next[w] = ages[w] + 1'b1;
            end
        end
    end

endmodule

// File: rtl/lc4_insn_cache_nway.sv
// N-way set-associative LC4 instruction cache: combinational lookup, one
// outstanding miss with hit-under-miss, per-set LRU replacement.
module lc4_insn_cache_nway
    import lc4_cache_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int SET_BITS = 6,
    parameter int WAYS     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  gwe,
    input  logic                  flush,
    input  logic [ADDR_W-1:0]     addr,
    output logic                  valid,
    output logic [DATA_W-1:0]     data,
    lc4_insn_cache_nway_if.master mem,
    output logic                  busy,
    output logic [15:0]           hit_cnt,
    output logic [15:0]           miss_cnt
);

    localparam int TAG_W = calc_tag_w(ADDR_W, SET_BITS);
    localparam int NSETS = 1 << SET_BITS;
    localparam int AW    = calc_age_store_w(WAYS);

    state_t            state_reg;
    logic [ADDR_W-1:0] miss_addr_reg;
    logic              mem_req_reg;
    logic              flushed_reg;
    logic [15:0]       hit_cnt_reg;
    logic [15:0]       miss_cnt_reg;

    logic [SET_BITS-1:0] addr_set, miss_set, upd_set;
    logic [TAG_W-1:0]    addr_tag, miss_tag;

    logic [WAYS-1:0]              addr_match, miss_match, set_valid;
    logic [WAYS-1:0][DATA_W-1:0]  way_data;
    logic [WAYS-1:0][AW-1:0]      set_ages, ages_next;
    logic [AW-1:0]                hit_way, victim;
    logic                         fill_en, hit_upd, lru_en, start_miss;

    assign addr_set = addr[SET_BITS-1:0];
    assign addr_tag = addr[ADDR_W-1:SET_BITS];
    assign miss_set = miss_addr_reg[SET_BITS-1:0];
    assign miss_tag = miss_addr_reg[ADDR_W-1:SET_BITS];
    assign upd_set  = (state_reg == ST_REQ) ? miss_set : addr_set;

    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
        logic [TAG_W-1:0]  tag_mem  [NSETS];
        logic [DATA_W-1:0] data_mem [NSETS];
        logic [AW-1:0]     age_mem  [NSETS];
        logic [NSETS-1:0]  valid_reg;

        assign addr_match[gi] = valid_reg[addr_set] && (tag_mem[addr_set] == addr_tag);
        assign miss_match[gi] = valid_reg[miss_set] && (tag_mem[miss_set] == miss_tag);
        assign way_data[gi]   = data_mem[addr_set];
        assign set_valid[gi]  = valid_reg[upd_set];
        assign set_ages[gi]   = age_mem[upd_set];

        always_ff @(posedge clk) begin
            if (!rst) begin
                valid_reg <= '0;
                for (int s = 0; s < NSETS; s++) age_mem[s] <= AW'(WAYS - 1 - gi);
            end else begin
                if (flush)
                    valid_reg <= '0;
                else if (fill_en && victim == AW'(gi))
                    valid_reg[miss_set] <= 1'b1;
                if (lru_en)
                    age_mem[upd_set] <= ages_next[gi];
            end
        end

        always_ff @(posedge clk) begin
            if (rst && fill_en && victim == AW'(gi)) begin
                tag_mem[miss_set]  <= miss_tag;
                data_mem[miss_set] <= mem.mem_idata;
            end
        end
    end

    always_comb begin
        data    = '0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (addr_match[w]) begin
                data    = data | way_data[w];
                hit_way = AW'(w);
            end
        end
    end
    assign valid = |addr_match;

    // A fill is dropped if the line arrived meanwhile or a flush hit this miss
    assign fill_en    = (state_reg == ST_REQ) && mem.mem_ack && !flushed_reg && !flush && !(|miss_match);
    assign hit_upd    = (state_reg == ST_IDLE) && valid && gwe;
    assign lru_en     = fill_en || hit_upd;
    assign start_miss = (state_reg == ST_IDLE) && !valid && !flush;

    lc4_cache_lru #(.WAYS(WAYS)) u_lru (
        .valid_bits (set_valid),
        .ages       (set_ages),
        .fill       (state_reg == ST_REQ),
        .hit_way    (hit_way),
        .victim     (victim),
        .ages_next  (ages_next)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            miss_addr_reg <= '0;
            mem_req_reg   <= 1'b0;
            flushed_reg   <= 1'b0;
            hit_cnt_reg   <= '0;
            miss_cnt_reg  <= '0;
        end else begin
            if (valid && gwe) hit_cnt_reg <= hit_cnt_reg + 16'd1;
            case (state_reg)
                ST_IDLE: begin
                    if (start_miss) begin
                        state_reg     <= ST_REQ;
                        miss_addr_reg <= addr;
                        mem_req_reg   <= 1'b1;
                        flushed_reg   <= 1'b0;
                        miss_cnt_reg  <= miss_cnt_reg + 16'd1;
                    end
                end
                ST_REQ: begin
                    if (flush) flushed_reg <= 1'b1;
                    if (mem.mem_ack) begin
                        state_reg   <= ST_IDLE;
                        mem_req_reg <= 1'b0;
                        flushed_reg <= 1'b0;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign mem.mem_req   = mem_req_reg;
    assign mem.mem_iaddr = mem_req_reg ? miss_addr_reg : '0;
    assign busy          = (state_reg != ST_IDLE);
    assign hit_cnt       = hit_cnt_reg;
    assign miss_cnt      = miss_cnt_reg;

endmodule

// File: tb/tb_lc4_insn_cache_nway.sv
// Self-checking bench: directed vector table, hand-written LRU/flush sequences,
// then randomized traffic against a recency-list reference model.
module tb_lc4_insn_cache_nway;

    localparam int WAYS  = 2;
    localparam int NSETS = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0, gwe = 1'b0, flush = 1'b0, ack = 1'b0;
    logic [15:0] addr = '0, idata = '0;
    logic        valid, busy;
    logic [15:0] data, hit_cnt, miss_cnt;

    always #5 clk = ~clk;

    lc4_insn_cache_nway_if #(.ADDR_W(16), .DATA_W(16)) mem_bus ();
    assign mem_bus.mem_ack   = ack;
    assign mem_bus.mem_idata = idata;

    lc4_insn_cache_nway #(.ADDR_W(16), .DATA_W(16), .SET_BITS(6), .WAYS(WAYS)) dut (
        .clk(clk), .rst(rst), .gwe(gwe), .flush(flush), .addr(addr),
        .valid(valid), .data(data), .mem(mem_bus), .busy(busy),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, settle, then return
    task automatic drive(input logic r, input logic g, input logic f,
                         input logic [15:0] a, input logic k, input logic [15:0] d);
        @(negedge clk);
        rst = r; gwe = g; flush = f; addr = a; ack = k; idata = d;
        #1;
    endtask

    task automatic do_fill(input logic [15:0] a, input logic [15:0] d);
        drive(1, 0, 0, a, 0, 0);
        chk($sformatf("fill %h miss", a), valid, 0);
        drive(1, 0, 0, a, 1, d);
        chk($sformatf("fill %h mem_req", a), mem_bus.mem_req, 1);
        chk($sformatf("fill %h mem_iaddr", a), mem_bus.mem_iaddr, a);
        $display("fill addr=%h data=%h", a, d);
    endtask

    task automatic probe(input logic [15:0] a, input logic ev, input logic [15:0] ed, input logic f);
        drive(1, 0, f, a, 0, 0);
        chk($sformatf("probe %h valid", a), valid, ev);
        chk($sformatf("probe %h data", a), data, ed);
        $display("probe addr=%h valid=%0b data=%h", a, valid, data);
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        v;
        logic [9:0]  tag;
        logic [15:0] d;
    } line_t;

    line_t       ml  [NSETS][WAYS];
    int          ord [NSETS][WAYS];   // ord[s][0] = most recently used way
    logic        m_busy, m_flushed;
    logic [15:0] m_maddr, m_hc, m_mc;

    function automatic void m_reset();
        for (int s = 0; s < NSETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                ml[s][w]  = '0;
                ord[s][w] = WAYS - 1 - w;
            end
        m_busy = 0; m_flushed = 0; m_maddr = 0; m_hc = 0; m_mc = 0;
    endfunction

    function automatic void m_lookup(input logic [15:0] a, output logic h, output int way,
                                     output logic [15:0] d);
        int s = int'(a[5:0]);
        h = 0; way = 0; d = 0;
        for (int w = 0; w < WAYS; w++)
            if (ml[s][w].v && ml[s][w].tag == a[15:6]) begin
                h = 1; way = w; d = ml[s][w].d;
            end
    endfunction

    function automatic void m_touch(input int s, input int k);
        int p = 0;
        for (int i = 0; i < WAYS; i++) if (ord[s][i] == k) p = i;
        for (int i = p; i > 0; i--) ord[s][i] = ord[s][i-1];
        ord[s][0] = k;
    endfunction

    function automatic void m_flush();
        for (int s = 0; s < NSETS; s++)
            for (int w = 0; w < WAYS; w++) ml[s][w].v = 0;
    endfunction

    function automatic void m_step(input logic r, input logic g, input logic f,
                                   input logic [15:0] a, input logic k, input logic [15:0] d);
        logic h, ph;
        int hw, pw, s, vic;
        logic [15:0] q, pq;
        if (!r) begin
            m_reset();
            return;
        end
        m_lookup(a, h, hw, q);
        if (h && g) m_hc = m_hc + 1;
        if (!m_busy) begin
            if (h && g) m_touch(int'(a[5:0]), hw);
            if (f) m_flush();
            if (!h && !f) begin
                m_busy = 1; m_maddr = a; m_flushed = 0; m_mc = m_mc + 1;
            end
        end else begin
            if (k) begin
                m_lookup(m_maddr, ph, pw, pq);
                if (!m_flushed && !f && !ph) begin
                    s = int'(m_maddr[5:0]);
                    vic = -1;
                    for (int w = WAYS - 1; w >= 0; w--) if (!ml[s][w].v) vic = w;
                    if (vic < 0) vic = ord[s][WAYS-1];
                    ml[s][vic] = '{v: 1'b1, tag: m_maddr[15:6], d: d};
                    m_touch(s, vic);
                end
                m_busy = 0;
                m_flushed = 0;
            end else if (f) begin
                m_flushed = 1;
            end
            if (f) m_flush();
        end
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        r, g, f;
        logic [15:0] a;
        logic        k;
        logic [15:0] d;
        logic        do_chk;
        logic        v;
        logic [15:0] q;
        logic        mr;
        logic [15:0] mia;
        logic        b;
        logic [15:0] hc, mc;
    } vec_t;

    vec_t tbl [15];

    initial begin
        logic        rr, rg, rf, rk, h;
        logic [15:0] ra, rd, q;
        int          w;

        tbl[0]  = '{0,1,0,16'h0040,0,16'h0000, 0, 0,16'h0000,0,16'h0000,0,16'd0,16'd0};
        tbl[1]  = '{1,1,0,16'h0040,0,16'h0000, 1, 0,16'h0000,0,16'h0000,0,16'd0,16'd0};
        tbl[2]  = '{1,1,0,16'h0040,0,16'h0000, 1, 0,16'h0000,1,16'h0040,1,16'd0,16'd1};
        tbl[3]  = '{1,1,0,16'h0040,0,16'h0000, 1, 0,16'h0000,1,16'h0040,1,16'd0,16'd1};
        tbl[4]  = '{1,1,0,16'h0040,1,16'hBEEF, 1, 0,16'h0000,1,16'h0040,1,16'd0,16'd1};
        tbl[5]  = '{1,1,0,16'h0040,0,16'h0000, 1, 1,16'hBEEF,0,16'h0000,0,16'd0,16'd1};
        tbl[6]  = '{1,1,0,16'h0040,0,16'h0000, 1, 1,16'hBEEF,0,16'h0000,0,16'd1,16'd1};
        tbl[7]  = '{0,1,0,16'h0000,0,16'h0000, 0, 0,16'h0000,0,16'h0000,0,16'd0,16'd0};
        tbl[8]  = '{1,1,0,16'h0000,0,16'h0000, 1, 0,16'h0000,0,16'h0000,0,16'd0,16'd0};
        tbl[9]  = '{1,1,0,16'h0000,0,16'h0000, 1, 0,16'h0000,1,16'h0000,1,16'd0,16'd1};
        tbl[10] = '{0,1,0,16'h0000,0,16'h0000, 1, 0,16'h0000,1,16'h0000,1,16'd0,16'd1};
        tbl[11] = '{1,1,0,16'h0000,1,16'h1234, 1, 0,16'h0000,0,16'h0000,0,16'd0,16'd0};
        tbl[12] = '{1,1,0,16'h0000,0,16'h0000, 1, 0,16'h0000,1,16'h0000,1,16'd0,16'd1};
        tbl[13] = '{1,1,0,16'h0000,1,16'h5555, 1, 0,16'h0000,1,16'h0000,1,16'd0,16'd1};
        tbl[14] = '{1,1,0,16'h0000,0,16'h0000, 1, 1,16'h5555,0,16'h0000,0,16'd0,16'd1};

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].r, tbl[i].g, tbl[i].f, tbl[i].a, tbl[i].k, tbl[i].d);
            if (tbl[i].do_chk) begin
                chk($sformatf("row%0d valid", i),     valid,             tbl[i].v);
                chk($sformatf("row%0d data", i),      data,              tbl[i].q);
                chk($sformatf("row%0d mem_req", i),   mem_bus.mem_req,   tbl[i].mr);
                chk($sformatf("row%0d mem_iaddr", i), mem_bus.mem_iaddr, tbl[i].mia);
                chk($sformatf("row%0d busy", i),      busy,              tbl[i].b);
                chk($sformatf("row%0d hit_cnt", i),   hit_cnt,           tbl[i].hc);
                chk($sformatf("row%0d miss_cnt", i),  miss_cnt,          tbl[i].mc);
            end
            $display("row %0d rst=%0b addr=%h ack=%0b valid=%0b data=%h mem_req=%0b busy=%0b",
                     i, tbl[i].r, tbl[i].a, tbl[i].k, valid, data, mem_bus.mem_req, busy);
        end

        // LRU: hit with gwe=1 on 0x0040 makes 0x0080 the victim
        drive(0, 0, 0, 16'h0000, 0, 0);
        do_fill(16'h0040, 16'h1111);
        do_fill(16'h0080, 16'h2222);
        drive(1, 1, 0, 16'h0040, 0, 0);
        chk("lru gwe1 hit 0040", valid, 1);
        do_fill(16'h00C0, 16'h3333);
        probe(16'h0040, 1, 16'h1111, 0);
        probe(16'h00C0, 1, 16'h3333, 0);
        probe(16'h0080, 0, 16'h0000, 0);

        // LRU: hit with gwe=0 leaves 0x0040 oldest, so it is evicted
        drive(0, 0, 0, 16'h0000, 0, 0);
        do_fill(16'h0040, 16'h1111);
        do_fill(16'h0080, 16'h2222);
        drive(1, 0, 0, 16'h0040, 0, 0);
        chk("lru gwe0 hit 0040", valid, 1);
        do_fill(16'h00C0, 16'h3333);
        probe(16'h0080, 1, 16'h2222, 0);
        probe(16'h00C0, 1, 16'h3333, 0);
        probe(16'h0040, 0, 16'h0000, 0);

        // Flush during REQ: ack still taken, fill discarded, everything misses
        drive(0, 0, 0, 16'h0000, 0, 0);
        do_fill(16'h0040, 16'h1111);
        drive(1, 0, 0, 16'h0100, 0, 0);
        drive(1, 0, 0, 16'h0040, 0, 0);
        chk("hum valid", valid, 1);
        chk("hum data", data, 16'h1111);
        chk("hum mem_iaddr", mem_bus.mem_iaddr, 16'h0100);
        drive(1, 0, 1, 16'h0100, 0, 0);
        chk("flush req held", mem_bus.mem_req, 1);
        drive(1, 0, 0, 16'h0100, 1, 16'hAAAA);
        chk("flush ack mem_req", mem_bus.mem_req, 1);
        drive(1, 0, 1, 16'h0100, 0, 0);
        chk("flush after mem_req", mem_bus.mem_req, 0);
        chk("flush after busy", busy, 0);
        chk("flush after valid 0100", valid, 0);
        chk("flush miss_cnt", miss_cnt, 16'd2);
        probe(16'h0040, 0, 16'h0000, 1);

        // Randomized traffic against the reference model
        m_reset();
        drive(0, 0, 0, 16'h0000, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            rr = ($urandom_range(0, 299) != 0);
            rg = ($urandom_range(0, 3) != 0);
            rf = ($urandom_range(0, 39) == 0);
            ra = {10'($urandom_range(0, 3)), 6'($urandom_range(0, 3))};
            rk = ($urandom_range(0, 2) == 0);
            rd = 16'($urandom);
            drive(rr, rg, rf, ra, rk, rd);
            m_lookup(ra, h, w, q);
            chk($sformatf("rnd%0d valid", i),     valid,             h);
            chk($sformatf("rnd%0d data", i),      data,              q);
            chk($sformatf("rnd%0d mem_req", i),   mem_bus.mem_req,   m_busy);
            chk($sformatf("rnd%0d mem_iaddr", i), mem_bus.mem_iaddr, m_busy ? m_maddr : 16'h0000);
            chk($sformatf("rnd%0d busy", i),      busy,              m_busy);
            chk($sformatf("rnd%0d hit_cnt", i),   hit_cnt,           m_hc);
            chk($sformatf("rnd%0d miss_cnt", i),  miss_cnt,          m_mc);
            if (i % 100 == 0)
                $display("rnd %0d addr=%h valid=%0b data=%h mem_req=%0b hits=%0d misses=%0d",
                         i, ra, valid, data, mem_bus.mem_req, hit_cnt, miss_cnt);
            m_step(rr, rg, rf, ra, rk, rd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lc4_insn_cache_nway.md
LC4_INSN_CACHE_NWAY -- requirements
Module: lc4_insn_cache_nway

Interface
REQ-001 Parameter ADDR_W, default 16, meaning instruction address width.
REQ-002 Parameter DATA_W, default 16, meaning instruction word width.
REQ-003 Parameter SET_BITS, default 6, meaning log2(number of sets); address = {tag, setid}, setid = addr[SET_BITS-1:0].
REQ-004 Parameter WAYS, default 2, meaning associativity; legal values 1, 2, 4, 8.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-low.
REQ-007 gwe  input  1  global write enable; qualifies hit-driven LRU and hit-counter updates.
REQ-008 flush  input  1  invalidates every line when high at a clock edge.
REQ-009 addr  input  ADDR_W  lookup address from the processor.
REQ-010 valid  output  1  current addr hits in the cache.
REQ-011 data  output  DATA_W  hit word; 0 when valid=0.
REQ-012 mem_req  output  1  fill request to instruction memory.
REQ-013 mem_iaddr  output  ADDR_W  fill address; 0 when mem_req=0.
REQ-014 mem_ack  input  1  memory returns mem_idata this cycle.
REQ-015 mem_idata  input  DATA_W  fill data, sampled only when mem_req & mem_ack.
REQ-016 busy  output  1  miss FSM not in IDLE.
REQ-017 hit_cnt, miss_cnt  output  16 each  wrapping performance counters.

Function
REQ-018 Lookup is combinational: valid=1 iff some way w in set setid has valid bit set and stored tag equal to addr tag; data = that way's word, same cycle.
REQ-019 Multiple matching ways cannot occur; a fill never writes a tag already present in the set.
REQ-020 FSM states IDLE, REQ; IDLE->REQ when valid=0 and flush=0; REQ->IDLE on mem_ack=1.
REQ-021 On IDLE->REQ the block latches addr as miss_addr; from the next cycle mem_req=1, mem_iaddr=miss_addr, both held stable until the ack cycle.
REQ-022 On the ack edge, victim way of set(miss_addr) receives {valid=1, tag, mem_idata}; the line hits from the following cycle.
REQ-023 Victim = lowest-index invalid way; if none, the way with maximum age.
REQ-024 LRU: per set, one age of log2(WAYS) bits per way; on access of way k, ways with age < age[k] increment, age[k] becomes 0; ages stay a permutation of 0..WAYS-1.
REQ-025 Access = fill (always) or hit in IDLE with gwe=1; a fill and a hit to the same set in one cycle apply the fill only.
REQ-026 In REQ, lookups continue (hit-under-miss) and return valid/data, but do not start a second miss or update LRU.
REQ-027 If the latched miss line becomes present before ack, the fill is dropped (no duplicate).
REQ-028 flush clears all valid bits at that edge; ages unchanged; flush in REQ keeps the request alive until ack, then discards the fill.
REQ-029 hit_cnt increments on each cycle with valid=1 and gwe=1; miss_cnt increments on each IDLE->REQ transition; both wrap 0xFFFF->0x0000.
REQ-030 WAYS=1 degenerates to direct-mapped; LRU logic is absent and victim is way 0.

Reset
REQ-031 While rst=0 at an edge: FSM=IDLE, all valid bits 0, age[w]=WAYS-1-w in every set, counters 0, miss_addr 0.
REQ-032 From the cycle after reset: valid=0, data=0, mem_req=0, mem_iaddr=0, busy=0; an ack arriving after a reset that interrupted REQ is ignored.

Structure
REQ-033 Package lc4_cache_pkg holds the FSM state enum, the derived TAG_W = ADDR_W-SET_BITS, and the AGE_W = $clog2(WAYS) helper.
REQ-034 Sub-module lc4_cache_lru computes next-state ages and victim index for one set; instantiated once, on the set being updated.

Verification (WAYS=2, SET_BITS=6)
REQ-035 Reset; addr=0x0040; ack after 3 REQ cycles with 0xBEEF -> mem_req=1 cycle 1, mem_iaddr=0x0040, valid=1 data=0xBEEF cycle after ack, miss_cnt=1.
REQ-036 After reset addr=0x0000 -> valid=0 and miss started (tag 0 on invalid line never hits).
REQ-037 Fill 0x0040, 0x0080, hit 0x0040 (gwe=1), miss 0x00C0 -> 0x0080 evicted; 0x0040 still hits, 0x0080 misses.
REQ-038 Hit 0x0040 with gwe=0 before the 0x00C0 miss -> 0x0040 evicted instead.
REQ-039 flush=1 during REQ for 0x0100 -> ack accepted, mem_req drops, 0x0100 and all prior lines miss afterwards.
REQ-040 rst=0 in REQ, ack one cycle later -> no line written, mem_req=0, busy=0, counters 0.
